// File: rtl/rx_receiver_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rx_receiver_if                                             |
// | Description : Bundle of serial-line inputs and packet/status outputs of  |
// |               the serial frame receiver.                                 |
// |   rx_line    1      serial line, one bit per clk                         |
// |   rx_enable  1      allows a new frame to start                          |
// |   clear_cnt  1      synchronous clear of the frame counters              |
// |   rx_packet  136    {header, payload left-aligned}                       |
// |   rx_valid   1      one-cycle strobe qualifying rx_packet/rx_crc_err     |
// |   rx_crc_err 1      received CRC differs from computed CRC               |
// |   rx_busy    1      a frame is being received                            |
// |   good_cnt   CNT_W  saturating count of CRC-good frames                  |
// |   err_cnt    CNT_W  saturating count of CRC-bad frames                   |
// |   master drives the line side; slave is the receiver.                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface rx_receiver_if #(
   parameter int CNT_W = 16
);
   logic             rx_line;
   logic             rx_enable;
   logic             clear_cnt;
   logic [135:0]     rx_packet;
   logic             rx_valid;
   logic             rx_crc_err;
   logic             rx_busy;
   logic [CNT_W-1:0] good_cnt;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      output rx_line, rx_enable, clear_cnt,
      input  rx_packet, rx_valid, rx_crc_err, rx_busy, good_cnt, err_cnt
   );

   modport slave (
      input  rx_line, rx_enable, clear_cnt,
      output rx_packet, rx_valid, rx_crc_err, rx_busy, good_cnt, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/rx_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rx_receiver                                                |
// | Description : Serial frame receiver. Hunts for an alternating preamble   |
// |               followed by SFD 8'hAB, deserialises an 8-bit header and    |
// |               (hdr[3:0]+1)*8 payload bits, checks a CRC-8 (poly 0x07)    |
// |               over the payload and presents a 136-bit packet with a      |
// |               one-cycle valid strobe. Keeps saturating good/bad counts.  |
// | Ports       : clk  - clock, line sampled every rising edge               |
// |               rst  - synchronous active-high reset                       |
// |               bus  - rx_receiver_if.slave (line in, packet/status out)   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module rx_receiver #(
   parameter int PRE_MIN = 8,
   parameter int CNT_W   = 16
) (
   input  logic         clk,
   input  logic         rst,
   rx_receiver_if.slave bus
);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_HEADER = 2'd1,
      S_DATA   = 2'd2,
      S_CRC    = 2'd3
   } state_t;

   localparam logic [7:0]       C_SFD     = 8'hAB;
   localparam logic [7:0]       C_POLY    = 8'h07;
   localparam logic [4:0]       C_PRE_MAX = 5'd31;
   localparam logic [4:0]       C_PRE_MIN = 5'(PRE_MIN);
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [6:0]       r_window;
   logic [4:0]       r_pre_cnt;
   logic [6:0]       r_bit_cnt;
   logic [6:0]       r_shift;
   logic [7:0]       r_hdr;
   logic [7:0]       r_crc;
   logic [127:0]     r_payload;
   logic [135:0]     r_packet;
   logic             r_valid;
   logic             r_crc_err;
   logic [CNT_W-1:0] r_good_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   logic [7:0]       w_win_next;
   logic             w_line_toggled;
   logic [7:0]       w_shift_full;
   logic [7:0]       w_crc_next;
   logic             w_crc_ok;
   logic             w_sfd_hit;
   logic             w_hdr_done;
   logic             w_data_done;
   logic             w_crc_done;

   // Window includes the bit currently on the line, so the SFD is matched
   // on the same edge its last bit is sampled.
   assign w_win_next     = {r_window, bus.rx_line};
   assign w_line_toggled = bus.rx_line ^ r_window[0];
   assign w_shift_full   = {r_shift, bus.rx_line};
   assign w_crc_next     = {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ bus.rx_line) ? C_POLY : 8'h00);
   assign w_crc_ok       = (w_shift_full == r_crc);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sfd_hit   = 1'b0;
      w_hdr_done  = 1'b0;
      w_data_done = 1'b0;
      w_crc_done  = 1'b0;
      case (r_state)
         S_HUNT: begin
            // pre_cnt is the run length before this bit; the SFD's own
            // alternating bits therefore contribute to it.
            if ((w_win_next == C_SFD) && (r_pre_cnt >= C_PRE_MIN) && bus.rx_enable) begin
               w_sfd_hit   = 1'b1;
               w_state_nxt = S_HEADER;
            end
         end
         S_HEADER: begin
            if (r_bit_cnt == 7'd7) begin
               w_hdr_done  = 1'b1;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            // last payload bit index is (hdr[3:0]+1)*8-1
            if (r_bit_cnt == {r_hdr[3:0], 3'b111}) begin
               w_data_done = 1'b1;
               w_state_nxt = S_CRC;
            end
         end
         S_CRC: begin
            if (r_bit_cnt == 7'd7) begin
               w_crc_done  = 1'b1;
               w_state_nxt = S_HUNT;
            end
         end
         default: w_state_nxt = S_HUNT;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_window  <= '0;
         r_pre_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_hdr     <= '0;
         r_crc     <= '0;
         r_payload <= '0;
         r_packet  <= '0;
         r_valid   <= 1'b0;
         r_crc_err <= 1'b0;
      end else begin
         r_valid <= 1'b0;

         // Window/run counter only live while hunting; holding them at zero
         // during a frame means a back-to-back preamble starts from scratch.
         if (r_state == S_HUNT) begin
            r_window <= w_win_next[6:0];
            if (w_line_toggled) begin
               r_pre_cnt <= (r_pre_cnt == C_PRE_MAX) ? r_pre_cnt : r_pre_cnt + 5'd1;
            end else begin
               r_pre_cnt <= 5'd0;
            end
         end else begin
            r_window  <= '0;
            r_pre_cnt <= '0;
         end

         case (r_state)
            S_HUNT: begin
               if (w_sfd_hit) begin
                  r_bit_cnt <= '0;
                  r_crc     <= '0;
                  r_payload <= '0;
               end
            end
            S_HEADER: begin
               r_shift   <= w_shift_full[6:0];
               r_bit_cnt <= w_hdr_done ? 7'd0 : r_bit_cnt + 7'd1;
               if (w_hdr_done) begin
                  r_hdr <= w_shift_full;
               end
            end
            S_DATA: begin
               r_payload[7'd127 - r_bit_cnt] <= bus.rx_line;
               r_crc     <= w_crc_next;
               r_bit_cnt <= w_data_done ? 7'd0 : r_bit_cnt + 7'd1;
            end
            S_CRC: begin
               r_shift   <= w_shift_full[6:0];
               r_bit_cnt <= w_crc_done ? 7'd0 : r_bit_cnt + 7'd1;
               if (w_crc_done) begin
                  r_valid   <= 1'b1;
                  r_packet  <= {r_hdr, r_payload};
                  r_crc_err <= ~w_crc_ok;
               end
            end
            default: ;
         endcase
      end
   end

   // ----------------------------------------------------------- counters
   // clear_cnt takes priority over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_good_cnt <= '0;
         r_err_cnt  <= '0;
      end else begin
         if (bus.clear_cnt) begin
            r_good_cnt <= '0;
         end else if (w_crc_done && w_crc_ok && (r_good_cnt != C_CNT_MAX)) begin
            r_good_cnt <= r_good_cnt + C_CNT_ONE;
         end

         if (bus.clear_cnt) begin
            r_err_cnt <= '0;
         end else if (w_crc_done && !w_crc_ok && (r_err_cnt != C_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + C_CNT_ONE;
         end
      end
   end

   assign bus.rx_packet  = r_packet;
   assign bus.rx_valid   = r_valid;
   assign bus.rx_crc_err = r_crc_err;
   assign bus.rx_busy    = (r_state != S_HUNT);
   assign bus.good_cnt   = r_good_cnt;
   assign bus.err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rx_receiver                                             |
// | Description : Self-checking bench for rx_receiver. A line stream of      |
// |               directed and random frames is built up front; a frame-     |
// |               level model scans it to predict every cycle's outputs,     |
// |               and one checker process compares the DUT each cycle.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_rx_receiver;
   localparam int PRE_MIN = 8;
   localparam int CNT_W   = 4;   // narrow so saturation is reached
   localparam int MAXL    = 8192;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rx_receiver_if #(.CNT_W(CNT_W)) bus ();

   rx_receiver #(.PRE_MIN(PRE_MIN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // stimulus, one entry per clock
   bit q_line[$];
   bit q_en[$];
   bit q_clr[$];
   bit q_rst[$];
   int L;

   // model predictions: output state after edge t
   bit               ev_valid[MAXL];
   bit               ev_err[MAXL];
   logic [135:0]     ev_pkt[MAXL];
   bit               exp_busy[MAXL];
   bit               exp_valid[MAXL];
   bit               exp_err[MAXL];
   logic [135:0]     exp_pkt[MAXL];
   logic [CNT_W-1:0] exp_good[MAXL];
   logic [CNT_W-1:0] exp_bad[MAXL];

   int n_checks = 0;
   int n_errs   = 0;
   int cur_t    = -1;
   int chk_t    = -1;

   task automatic chk(input string name, input int t, input logic [135:0] act, input logic [135:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s t=%0d got=%h expected=%h", name, t, act, exp);
      end
   endtask

   function automatic logic [7:0] crc8(input logic [127:0] d, input int n);
      logic [7:0] c = 8'h00;
      for (int k = 0; k < n; k++) begin
         if (c[7] ^ d[127-k]) c = {c[6:0], 1'b0} ^ 8'h07;
         else                 c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

   task automatic push(input bit b, input bit r = 1'b0);
      q_line.push_back(b);
      q_en.push_back(1'b1);
      q_clr.push_back(1'b0);
      q_rst.push_back(r);
   endtask

   task automatic push_idle(input int n, input bit v);
      for (int i = 0; i < n; i++) push(v);
   endtask

   // Preamble ends in 0 so it flows into the SFD's leading 1. flip>=0 inverts
   // that payload bit on the line while the CRC is taken over the original.
   task automatic push_frame(input int pre_len, input logic [7:0] hdr, input logic [127:0] data,
                             input int flip, output int sfd_idx, output int end_idx);
      int         n;
      logic [7:0] c;
      logic [7:0] sfd;
      n   = (int'(hdr[3:0]) + 1) * 8;
      c   = crc8(data, n);
      sfd = 8'hAB;
      for (int i = 0; i < pre_len; i++) push(((pre_len - 1 - i) % 2) == 1);
      for (int i = 0; i < 8; i++) push(sfd[7-i]);
      sfd_idx = q_line.size() - 1;
      for (int i = 0; i < 8; i++) push(hdr[7-i]);
      for (int k = 0; k < n; k++) push(data[127-k] ^ (k == flip));
      for (int i = 0; i < 8; i++) push(c[7-i]);
      end_idx = q_line.size() - 1;
   endtask

   function automatic bit bit_at(input int i);
      return (i < L) ? q_line[i] : 1'b0;
   endfunction

   // Hunt starts fresh at index h: earlier history reads as zeros.
   function automatic bit accept_at(input int t, input int h);
      logic [7:0] w;
      int         run;
      bit         prev;
      for (int i = 0; i < 8; i++) begin
         int idx = t - 7 + i;
         w[7-i] = (idx >= h) ? q_line[idx] : 1'b0;
      end
      run = 0;
      for (int k = t - 1; k >= h && run < 31; k--) begin
         prev = (k > h) ? q_line[k-1] : 1'b0;
         if (q_line[k] != prev) run++;
         else break;
      end
      return (w == 8'hAB) && (run >= PRE_MIN) && q_en[t];
   endfunction

   task automatic build_model();
      int t, h, n, e, r;
      logic [7:0]   hdr, rxc;
      logic [127:0] pl;
      logic [CNT_W-1:0] g, b;
      logic [135:0] pkt;
      bit           err;
      for (int i = 0; i < MAXL; i++) begin
         ev_valid[i] = 0; ev_err[i] = 0; ev_pkt[i] = '0; exp_busy[i] = 0;
      end
      h = 0;
      t = 0;
      while (t < L) begin
         if (q_rst[t]) begin
            h = t + 1;
            t++;
            continue;
         end
         if (accept_at(t, h)) begin
            for (int i = 0; i < 8; i++) hdr[7-i] = bit_at(t + 1 + i);
            n = (int'(hdr[3:0]) + 1) * 8;
            e = t + 16 + n;
            r = -1;
            for (int x = t + 1; x <= e && x < L; x++) begin
               if (q_rst[x]) begin r = x; break; end
            end
            if (r >= 0) begin
               for (int x = t; x < r; x++) exp_busy[x] = 1;
               t = r;
               continue;
            end
            if (e >= L) begin
               for (int x = t; x < L; x++) exp_busy[x] = 1;
               break;
            end
            pl = '0;
            for (int k = 0; k < n; k++) pl[127-k] = bit_at(t + 9 + k);
            for (int i = 0; i < 8; i++) rxc[7-i] = bit_at(t + 9 + n + i);
            for (int x = t; x < e; x++) exp_busy[x] = 1;
            ev_valid[e] = 1;
            ev_pkt[e]   = {hdr, pl};
            ev_err[e]   = (rxc != crc8(pl, n));
            h = e + 1;
            t = e + 1;
            continue;
         end
         t++;
      end
      // hold registers and saturating counters
      pkt = '0; err = 0; g = '0; b = '0;
      for (int x = 0; x < L; x++) begin
         if (q_rst[x]) begin
            pkt = '0; err = 0; g = '0; b = '0;
         end else begin
            if (ev_valid[x]) begin
               pkt = ev_pkt[x];
               err = ev_err[x];
            end
            if (q_clr[x]) g = '0;
            else if (ev_valid[x] && !ev_err[x] && g != '1) g = g + 1'b1;
            if (q_clr[x]) b = '0;
            else if (ev_valid[x] && ev_err[x] && b != '1) b = b + 1'b1;
         end
         exp_valid[x] = ev_valid[x] && !q_rst[x];
         exp_pkt[x]   = pkt;
         exp_err[x]   = err;
         exp_good[x]  = g;
         exp_bad[x]   = b;
      end
   endtask

   function automatic int busy_count(input int a, input int z);
      int c = 0;
      for (int x = a; x <= z; x++) c += exp_busy[x];
      return c;
   endfunction

   function automatic int valid_count(input int a, input int z);
      int c = 0;
      for (int x = a; x <= z; x++) c += exp_valid[x];
      return c;
   endfunction

   // ------------------------------------------------------------- checker
   always @(posedge clk) begin
      #1;
      if (cur_t >= 0 && cur_t != chk_t) begin
         chk_t = cur_t;
         chk("rx_valid",   chk_t, bus.rx_valid,   exp_valid[chk_t]);
         chk("rx_busy",    chk_t, bus.rx_busy,    exp_busy[chk_t]);
         chk("rx_packet",  chk_t, bus.rx_packet,  exp_pkt[chk_t]);
         chk("rx_crc_err", chk_t, bus.rx_crc_err, exp_err[chk_t]);
         chk("good_cnt",   chk_t, bus.good_cnt,   exp_good[chk_t]);
         chk("err_cnt",    chk_t, bus.err_cnt,    exp_bad[chk_t]);
      end
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      int sA, eA, sB, eB, sC, eC, sS, eS, sD1, eD1, sD2, eD2;
      int sR, eR, sR2, eR2, sE, eE, sM, eM, sx, ex, rnd_start;
      logic [127:0] dB;
      logic [7:0]   sfd;

      bus.rx_line   = 1'b0;
      bus.rx_enable = 1'b0;
      bus.clear_cnt = 1'b0;

      for (int i = 0; i < 3; i++) push(1'b0, 1'b1);
      push_idle(5, 1'b0);
      push_frame(16, 8'h00, {8'hFF, 120'h0}, -1, sA, eA);
      push_idle(4, 1'b0);
      dB = {$urandom(), $urandom(), $urandom(), $urandom()};
      push_frame(16, 8'h0F, dB, -1, sB, eB);
      push_idle(3, 1'b0);
      // data 8'h01 sent with its MSB inverted, CRC of 8'h01 (8'h07) appended
      push_frame(16, 8'h00, {8'h01, 120'h0}, 0, sC, eC);
      // no preamble: only the SFD's own 6 transitions precede its last bit
      push_idle(6, 1'b1);
      sS  = q_line.size();
      sfd = 8'hAB;
      for (int i = 0; i < 8; i++) push(sfd[7-i]);
      push_idle(10, 1'b0);
      eS = q_line.size() - 1;
      push_frame(16, 8'h01, {$urandom(), 96'h0}, -1, sD1, eD1);
      push_frame(16, 8'h02, {$urandom(), $urandom(), 64'h0}, -1, sD2, eD2);
      push_idle(2, 1'b0);
      push_frame(16, 8'h03, 128'h0, -1, sR, eR);
      q_rst[sR + 20] = 1'b1;
      push_frame(12, 8'h00, {8'h5A, 120'h0}, -1, sR2, eR2);
      push_idle(3, 1'b0);
      push_frame(16, 8'h00, 128'h0, -1, sE, eE);
      q_en[sE] = 1'b0;
      push_idle(3, 1'b0);
      push_frame(16, 8'h01, {16'hC3A5, 112'h0}, -1, sM, eM);
      for (int x = sM + 1; x <= eM; x++) q_en[x] = 1'b0;
      q_clr[eM] = 1'b1;
      rnd_start = q_line.size();
      for (int f = 0; f < 22; f++) begin
         logic [7:0]   hdr;
         logic [127:0] d;
         int           pre, n, flip;
         pre  = ($urandom_range(3, 0) == 0) ? $urandom_range(4, 0) : $urandom_range(16, 8);
         hdr  = 8'($urandom());
         n    = (int'(hdr[3:0]) + 1) * 8;
         d    = {$urandom(), $urandom(), $urandom(), $urandom()};
         flip = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
         push_frame(pre, hdr, d, flip, sx, ex);
         if ($urandom_range(7, 0) == 0)  q_en[sx] = 1'b0;
         if ($urandom_range(11, 0) == 0) q_rst[sx + $urandom_range(n + 16, 1)] = 1'b1;
         for (int g = $urandom_range(6, 0); g > 0; g--) push(1'($urandom_range(1, 0)));
      end
      push_idle(170, 1'b0);
      for (int i = 0; i < 10; i++) q_clr[$urandom_range(q_line.size() - 1, rnd_start)] = 1'b1;
      L = q_line.size();
      if (L > MAXL) begin
         $display("FAIL stim_length got=%0d limit=%0d", L, MAXL);
         $fatal(1, "stimulus too long");
      end

      build_model();

      // hand-computed pins on the model
      chk("crc_ff",       0,   crc8({8'hFF, 120'h0}, 8), 8'hF3);
      chk("crc_01",       0,   crc8({8'h01, 120'h0}, 8), 8'h07);
      chk("A_valid",      eA,  exp_valid[eA], 1'b1);
      chk("A_latency",    eA,  exp_valid[eA-1], 1'b0);
      chk("A_packet",     eA,  exp_pkt[eA], {8'h00, 8'hFF, 120'h0});
      chk("A_err",        eA,  exp_err[eA], 1'b0);
      chk("A_good",       eA,  exp_good[eA], 4'd1);
      chk("B_busy_len",   eB,  busy_count(sB - 1, eB), 144);
      chk("B_payload",    eB,  exp_pkt[eB][127:0], dB);
      chk("B_good",       eB,  exp_good[eB], 4'd2);
      chk("C_err",        eC,  exp_err[eC], 1'b1);
      chk("C_errcnt",     eC,  exp_bad[eC], 4'd1);
      chk("C_good",       eC,  exp_good[eC], 4'd2);
      chk("S_no_busy",    eS,  busy_count(sS, eS), 0);
      chk("D_two_valid",  eD2, valid_count(sD1, eD2), 2);
      chk("D_good",       eD2, exp_good[eD2], 4'd4);
      chk("R_no_valid",   eR,  valid_count(sR, eR), 0);
      chk("R2_valid",     eR2, exp_valid[eR2], 1'b1);
      chk("R2_good",      eR2, exp_good[eR2], 4'd1);
      chk("E_no_busy",    eE,  busy_count(sE, eE), 0);
      chk("M_valid",      eM,  exp_valid[eM], 1'b1);
      chk("M_clear_wins", eM,  exp_good[eM], 4'd0);

      for (int t = 0; t < L; t++) begin
         @(negedge clk);
         rst           = q_rst[t];
         bus.rx_line   = q_line[t];
         bus.rx_enable = q_en[t];
         bus.clear_cnt = q_clr[t];
         cur_t         = t;
      end
      @(negedge clk);
      @(negedge clk);
      chk("all_cycles_checked", chk_t, chk_t, L - 1);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end
endmodule
`default_nettype wire
